w_grad_blend: RTL

- Consumer of the 8-bit blending weight w_grad_f produced by the gradient-weight stage.
- Applies the weight to two candidate pixel estimates: pix_out = round((w*pix_a + (255-w)*pix_b)/255).
- Normalisation by 255 uses an iterative restoring divider. One transaction is in flight at a time, with a valid/ready handshake on both sides.
- Sits between weight generation and the CFA interpolation output stage.

---
 rtl/w_grad_blend_pkg.sv | 20 ++
 rtl/w_grad_blend_if.sv | 25 ++
 rtl/w_grad_blend_divider.sv | 68 ++++++
 rtl/w_grad_blend.sv | 112 +++++++++++
 4 files changed

// File: rtl/w_grad_blend_pkg.sv
// Shared constants and FSM encoding for the gradient-weight blend stage.
package w_grad_blend_pkg;

  localparam int DATA_W_DEF = 8;

  function automatic int wmax_of(input int width);
    return (1 << width) - 1;
  endfunction

  localparam int WMAX      = wmax_of(DATA_W_DEF);
  localparam int RND_CONST = WMAX >> 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/w_grad_blend_if.sv
// Input-triple and output-pixel handshakes of the blend stage.
// Both sides: a transfer happens on a rising edge where valid and ready are both 1;
// a producer holds valid and its data stable until that edge, and ready never waits on valid.
interface w_grad_blend_if #(
  parameter int DATA_W = w_grad_blend_pkg::DATA_W_DEF
);
  logic [DATA_W-1:0] w_grad_f;
  logic [DATA_W-1:0] pix_a;
  logic [DATA_W-1:0] pix_b;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] pix_out;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output w_grad_f, pix_a, pix_b, in_valid, out_ready,
    input  in_ready, pix_out, out_valid
  );

  modport slave (
    input  w_grad_f, pix_a, pix_b, in_valid, out_ready,
    output in_ready, pix_out, out_valid
  );
endinterface

// File: rtl/w_grad_blend_divider.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Assumes DIVIDEND_W == DIVISOR_W + QUOT_W and that the quotient fits QUOT_W bits.
module seq_restoring_divider #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8,
  parameter int QUOT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0]  remainder
);

  localparam int CNT_W = (QUOT_W > 1) ? $clog2(QUOT_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(QUOT_W - 1);

  logic [DIVISOR_W-1:0] rem_r;
  logic [QUOT_W-1:0]    quo_r;
  logic [DIVISOR_W-1:0] dvsr_r;
  logic [CNT_W-1:0]     cnt;
  logic                 busy_r;

  logic [DIVISOR_W:0]   trial;
  logic                 ge;
  logic [DIVISOR_W-1:0] rem_nxt;
  logic [QUOT_W-1:0]    quo_nxt;

  // quo_r shifts dividend bits out at the top and quotient bits in at the bottom.
  always_comb begin
    trial   = {rem_r, quo_r[QUOT_W-1]};
    ge      = (trial >= {1'b0, dvsr_r});
    rem_nxt = ge ? DIVISOR_W'(trial - {1'b0, dvsr_r}) : trial[DIVISOR_W-1:0];
    quo_nxt = {quo_r[QUOT_W-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r  <= '0;
      quo_r  <= '0;
      dvsr_r <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
    end else if (start) begin
      rem_r  <= dividend[DIVIDEND_W-1 -: DIVISOR_W];
      quo_r  <= dividend[QUOT_W-1:0];
      dvsr_r <= divisor;
      cnt    <= '0;
      busy_r <= 1'b1;
    end else if (busy_r) begin
      rem_r <= rem_nxt;
      quo_r <= quo_nxt;
      cnt   <= cnt + 1'b1;
      if (cnt == LAST) busy_r <= 1'b0;
    end
  end

  // The final step's result is presented combinationally alongside done.
  assign busy      = busy_r;
  assign done      = busy_r && (cnt == LAST);
  assign quotient  = quo_nxt;
  assign remainder = rem_nxt;

endmodule

// File: rtl/w_grad_blend.sv
// Blends two candidate pixels by an 8-bit gradient weight and normalises by WMAX
// with a sequential divider; one transaction in flight at a time.
module w_grad_blend
  import w_grad_blend_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter bit ROUND_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  w_grad_blend_if.slave              bus,
  output state_t                     dbg_state,
  output logic [$clog2(DATA_W)-1:0]  dbg_iter,
  output logic                       dbg_div_busy,
  output logic [DATA_W-1:0]          dbg_div_rem
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] WMAX_L = DATA_W'(wmax_of(DATA_W));
  localparam logic [DATA_W-1:0] RND_L  = WMAX_L >> 1;

  state_t            state;
  logic [DATA_W-1:0] w_r, a_r, b_r;
  logic [CNT_W-1:0]  iter;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] dividend;

  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [DATA_W-1:0] div_quot;
  logic [DATA_W-1:0] div_rem;

  // Peak is WMAX*WMAX (+WMAX/2), so PROD_W bits never overflow.
  always_comb begin
    prod = PROD_W'(w_r) * PROD_W'(a_r)
         + PROD_W'(WMAX_L - w_r) * PROD_W'(b_r);
    dividend = prod + (ROUND_EN ? PROD_W'(RND_L) : '0);
  end

  assign div_start = (state == MUL);

  seq_restoring_divider #(
    .DIVIDEND_W (PROD_W),
    .DIVISOR_W  (DATA_W),
    .QUOT_W     (DATA_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (dividend),
    .divisor   (WMAX_L),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.pix_out   <= '0;
      w_r           <= '0;
      a_r           <= '0;
      b_r           <= '0;
      iter          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            w_r          <= bus.w_grad_f;
            a_r          <= bus.pix_a;
            b_r          <= bus.pix_b;
            bus.in_ready <= 1'b0;
            state        <= MUL;
          end
        end
        MUL: begin
          iter  <= '0;
          state <= DIV;
        end
        DIV: begin
          if (div_done) begin
            bus.pix_out   <= div_quot;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            iter <= iter + 1'b1;
          end
        end
        DONE: begin
          // pix_out is left as-is after the handshake.
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state    = state;
  assign dbg_iter     = iter;
  assign dbg_div_busy = div_busy;
  assign dbg_div_rem  = div_rem;

endmodule
